// File: rtl/serial_rx_arbiter_pkg.sv
// Shared definitions for the serial receive arbiter: FSM state encodings and
// default sizing constants.
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_BUSY    = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_t;

    localparam int ARB_N_DEFAULT       = 4;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage : arb_defs

// File: rtl/serial_rx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping from N-1 back to 0.
module rr_picker
    import arb_defs::*;
#(
    parameter int N = ARB_N_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  onehot_s;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic [IW-1:0] cand_s;

    // Scan the requests starting at the pointer; the first hit wins.
    always_comb begin
        onehot_s = '0;
        idx_s    = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = IW'((int'(ptr) + i) % N);
            if (!found_s && req[cand_s]) begin
                found_s          = 1'b1;
                onehot_s[cand_s] = 1'b1;
                idx_s            = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign onehot = onehot_s;
    assign idx    = idx_s;
    assign any    = found_s;

endmodule : rr_picker

// File: rtl/serial_rx_arbiter.sv
// Round-robin arbiter sharing one serial frame engine among N requesters.
// Define ARB_TIMEOUT_EN to add the start-bit timeout and timeoutErr pulse.
module serial_rx_arbiter
    import arb_defs::*;
#(
    parameter int N = ARB_N_DEFAULT
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         serLines,
    input  logic                 engDone,
    output logic                 serIn,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] grantId,
    output logic                 busy,
    output logic                 timeoutErr
);

    localparam int IW = $clog2(N);

    arb_state_t    state_r;
    arb_state_t    next_state_s;
    logic [N-1:0]  gnt_r;
    logic [IW-1:0] grant_id_r;
    logic [IW-1:0] rr_ptr_r;
    logic          busy_r;
    logic [N-1:0]  pick_onehot_s;
    logic [IW-1:0] pick_idx_s;
    logic          pick_any_s;
    logic          do_grant_s;
    logic          do_release_s;
    logic          to_hit_s;
    logic [IW-1:0] ptr_next_s;

    rr_picker #(.N(N)) u_picker (
        .req    (req),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign ptr_next_s = (grant_id_r == IW'(N - 1)) ? '0 : (grant_id_r + IW'(1));

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt_r;
    logic          timeout_err_r;

    // Count enabled cycles spent in GRANT waiting for the start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_r <= '0;
        end else if (clkEn) begin
            if (state_r == ST_GRANT && engDone) begin
                tcnt_r <= tcnt_r + CW'(1);
            end else begin
                tcnt_r <= '0;
            end
        end
    end

    assign to_hit_s = (tcnt_r == CW'(TIMEOUT - 1));

    // One-cycle error pulse when the grant is abandoned for lack of a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= clkEn && (state_r == ST_GRANT) && engDone
                             && req[grant_id_r] && to_hit_s;
        end
    end

    assign timeoutErr = timeout_err_r;
`else
    assign to_hit_s   = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    // Next-state decode; a falling engDone in GRANT wins over a dropped req.
    always_comb begin
        next_state_s = state_r;
        do_grant_s   = 1'b0;
        do_release_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (engDone && pick_any_s) begin
                    next_state_s = ST_GRANT;
                    do_grant_s   = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!engDone) begin
                    next_state_s = ST_BUSY;
                end else if (!req[grant_id_r] || to_hit_s) begin
                    next_state_s = ST_RELEASE;
                    do_release_s = 1'b1;
                end else begin
                    next_state_s = ST_GRANT;
                end
            end
            ST_BUSY: begin
                if (engDone) begin
                    next_state_s = ST_RELEASE;
                    do_release_s = 1'b1;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register, advancing only on enabled edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else if (clkEn) begin
            state_r <= next_state_s;
        end
    end

    // Grant, winner index and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r      <= '0;
            grant_id_r <= '0;
            rr_ptr_r   <= '0;
        end else if (clkEn) begin
            if (do_grant_s) begin
                gnt_r      <= pick_onehot_s;
                grant_id_r <= pick_idx_s;
            end else if (do_release_s) begin
                gnt_r    <= '0;
                rr_ptr_r <= ptr_next_s;
            end
        end
    end

    // Busy flag tracks the registered state leaving IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
        end else if (clkEn) begin
            busy_r <= (next_state_s != ST_IDLE);
        end
    end

    // Unregistered so the engine sees the requester's line bit-aligned.
    assign serIn   = (gnt_r != '0) ? serLines[grant_id_r] : 1'b1;
    assign gnt     = gnt_r;
    assign grantId = grant_id_r;
    assign busy    = busy_r;

endmodule : serial_rx_arbiter

// File: tb/tb_serial_rx_arbiter.sv
// Table-driven directed bench for serial_rx_arbiter (N=4), plus hand-written
// sequences for long frames, mid-frame reset and the optional timeout.
module tb_serial_rx_arbiter;

    logic       clk;
    logic       rst;
    logic       clkEn;
    logic [3:0] req;
    logic [3:0] serLines;
    logic       engDone;
    logic       serIn;
    logic [3:0] gnt;
    logic [1:0] grantId;
    logic       busy;
    logic       timeoutErr;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] req;
        logic [3:0] ser;
        logic       done;
        logic       en;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       sin;
    } vec_t;

    vec_t vecs[34];

    serial_rx_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .clkEn      (clkEn),
        .req        (req),
        .serLines   (serLines),
        .engDone    (engDone),
        .serIn      (serIn),
        .gnt        (gnt),
        .grantId    (grantId),
        .busy       (busy),
        .timeoutErr (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // req, ser, done, en  ->  gnt, id, busy, serIn
        vecs[0]  = '{4'b0100, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[1]  = '{4'b0100, 4'b1011, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 4'b1011, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[4]  = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b1};
        vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[6]  = '{4'b1111, 4'b0111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'b1111, 4'b0111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[8]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b1};
        vecs[9]  = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b1};
        vecs[10] = '{4'b1111, 4'b1110, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{4'b1111, 4'b1110, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1};
        vecs[13] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
        vecs[14] = '{4'b1111, 4'b1101, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{4'b1111, 4'b1101, 1'b0, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[16] = '{4'b1111, 4'b1101, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[17] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[18] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[19] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[20] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b1};
        vecs[21] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1};
        vecs[22] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[23] = '{4'b1011, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b1};
        vecs[24] = '{4'b1011, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1};
        vecs[25] = '{4'b1011, 4'b0111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[26] = '{4'b1011, 4'b0111, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[27] = '{4'b1011, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b1};
        vecs[28] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b1};
        vecs[29] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b1};
        vecs[30] = '{4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[31] = '{4'b0000, 4'b1110, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[32] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1};
        vecs[33] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};

        rst      = 1'b0;
        clkEn    = 1'b1;
        req      = 4'b0000;
        serLines = 4'b1111;
        engDone  = 1'b1;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_serIn", 32'(serIn), 32'h1);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_grantId", 32'(grantId), 32'h0);
        chk("reset_timeoutErr", 32'(timeoutErr), 32'h0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 34; i++) begin
            req      = vecs[i].req;
            serLines = vecs[i].ser;
            engDone  = vecs[i].done;
            clkEn    = vecs[i].en;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_grantId", i), 32'(grantId), 32'(vecs[i].id));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_serIn", i), 32'(serIn), 32'(vecs[i].sin));
            chk($sformatf("v%0d_timeoutErr", i), 32'(timeoutErr), 32'h0);
        end

        // Long frame on requester 2, then check the pointer moved to 3.
        clkEn = 1'b1;
        req = 4'b0100; serLines = 4'b1111; engDone = 1'b1;
        step();
        chk("long_grant", 32'(gnt), 32'h4);
        serLines = 4'b1011; engDone = 1'b0;
        step();
        for (int i = 0; i < 18; i++) begin
            serLines = (i % 2 == 0) ? 4'b1111 : 4'b1011;
            step();
        end
        chk("long_hold_gnt", 32'(gnt), 32'h4);
        chk("long_hold_busy", 32'(busy), 32'h1);
        chk("long_hold_serIn", 32'(serIn), 32'h0);
        serLines = 4'b1111; engDone = 1'b1;
        step();
        chk("long_release_gnt", 32'(gnt), 32'h0);
        chk("long_release_busy", 32'(busy), 32'h1);
        req = 4'b1111;
        step();
        chk("long_idle_busy", 32'(busy), 32'h0);
        step();
        chk("long_next_gnt", 32'(gnt), 32'h8);
        chk("long_next_id", 32'(grantId), 32'h3);

        // Reset mid-frame.
        serLines = 4'b0111; engDone = 1'b0;
        step();
        chk("busy_before_rst", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_serIn", 32'(serIn), 32'h1);
        chk("rst_grantId", 32'(grantId), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        engDone = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst_hold%0d_gnt", i), 32'(gnt), 32'h0);
        end
        rst = 1'b1;
        serLines = 4'b1111;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_id", 32'(grantId), 32'h0);

`ifdef ARB_TIMEOUT_EN
        // No start bit: the 16th enabled cycle in GRANT abandons the grant.
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("to_wait%0d_err", i), 32'(timeoutErr), 32'h0);
            chk($sformatf("to_wait%0d_gnt", i), 32'(gnt), 32'h1);
        end
        step();
        chk("to_fire_err", 32'(timeoutErr), 32'h1);
        chk("to_fire_gnt", 32'(gnt), 32'h0);
        step();
        chk("to_after_err", 32'(timeoutErr), 32'h0);
        chk("to_after_busy", 32'(busy), 32'h0);
        step();
        chk("to_next_gnt", 32'(gnt), 32'h2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_rx_arbiter

// File: doc/serial_rx_arbiter.md
# serial_rx_arbiter

Round-robin arbiter that shares one serial frame-receive engine among N serial requesters. It sits in front of the frame controller/datapath. Requesters raise `req` and wait for `gnt`. The arbiter routes the granted line onto the engine's single `serIn`, holds the grant while the engine is mid-frame, and releases it when the engine reports `Done` again.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 16: enabled cycles a granted requester has to send its start bit (timeout build only).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clkEn`  in  1  state-advance enable, shared with the frame engine.
- `req`  in  N  request per requester; level, held until granted.
- `serLines`  in  N  per-requester serial lines; idle high.
- `engDone`  in  1  frame engine `Done`; 1 = engine idle.
- `serIn`  out  1  muxed serial line to the engine.
- `gnt`  out  N  one-hot grant; all-zero when not granted.
- `grantId`  out  clog2(N)  index of the current or last winner.
- `busy`  out  1  arbiter is not in IDLE.
- `timeoutErr`  out  1  one-cycle pulse on grant timeout (timeout build only).

## Operation
- States: IDLE, GRANT, BUSY, RELEASE.
- IDLE → GRANT when `engDone`=1 and `req`≠0.
  - Winner is the first set `req` bit at or after `rrPtr`, wrapping from N-1 to 0.
  - The winner's bit is registered into `gnt` and its index into `grantId`.
- GRANT → BUSY when `engDone`=0, meaning the engine has consumed the start bit.
- GRANT → RELEASE when the granted `req` bit drops before the start bit (cancel).
- BUSY → RELEASE when `engDone` returns to 1 (frame complete). `req` is ignored in BUSY.
- RELEASE → IDLE unconditionally.
  - `gnt` clears on entry to RELEASE.
  - `rrPtr` ← (`grantId`+1) mod N.
- Mux rule: `serIn` = `serLines[grantId]` when `gnt`≠0, else 1. This keeps the engine parked in its idle state.
- Reset values: state IDLE, `gnt`=0, `grantId`=0, `rrPtr`=0, `busy`=0, `serIn`=1, `timeoutErr`=0.
- `busy` = 1 in GRANT, BUSY and RELEASE.
- A requester that is refused stays pending. Fairness: any continuously asserted `req` is granted within N grants.

## Timing
- All state, `gnt`, `rrPtr` and timeout counter updates occur only on `clk` edges with `clkEn`=1. With `clkEn`=0 everything holds.
- `serIn` is combinational from registered `gnt`/`grantId` and the live `serLines`. There are no registers in that path, so it stays bit-aligned with the engine.
- Grant latency: `gnt` is visible after the first enabled edge at which IDLE sees `req` with `engDone`=1.
- Minimum gap between grants: 2 enabled cycles (RELEASE, then IDLE).
- Simultaneous requests: only one winner per grant; the remaining bits are unaffected.
- If `req` and `engDone` fall in the same GRANT cycle, go to BUSY: the frame has already started.
- `engDone`=0 while in IDLE (engine busy from an external cause): no grant is issued.
- `rst` asserted mid-frame: immediate return to reset values and `serIn`=1. The engine must be reset by the same `rst`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs in GRANT. After `TIMEOUT` enabled cycles with `engDone` still 1, go to RELEASE and pulse `timeoutErr` for one cycle.
  - `rrPtr` advances past the offender as in a normal release.
- `ARB_TIMEOUT_EN` undefined:
  - No counter and no `TIMEOUT` parameter use. `timeoutErr` is tied to 0.
  - GRANT waits indefinitely.

## Structure
- Shared package/header `arb_defs`:
  - state encodings (IDLE=2'b00, GRANT=2'b01, BUSY=2'b10, RELEASE=2'b11);
  - the default `N` and `TIMEOUT` constants.
- One sub-module, `rr_picker`: combinational; takes `req` and `rrPtr`, returns one-hot winner and index.
- FSM, pointer, counter and mux stay in the top.

## Test plan
- Reset with `req`=4'b0000: `gnt`=0, `serIn`=1, `busy`=0. Then `req`=4'b0100 with `engDone`=1 → `gnt`=4'b0100 and `grantId`=2 after one enabled edge.
- Grant to requester 2; drive `serLines[2]` low and `engDone` 1→0, then back to 1 after 18 cycles → BUSY, then RELEASE, `gnt`=0, `rrPtr`=3.
- `req`=4'b1111 held for four frames → grant order 0,1,2,3.
- `clkEn` toggling 1/0 throughout → every transition occurs only on enabled edges, and the grant order is unchanged.
- Granted requester drops `req` before its start bit → RELEASE, no frame, next requester granted. With `ARB_TIMEOUT_EN`, `TIMEOUT`=16 and no start bit → `timeoutErr` pulses on the 16th enabled cycle.
- Assert `rst` low during BUSY → `gnt`=0, `serIn`=1, `grantId`=0 immediately; no spurious grant until `rst` releases.
